// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order result FIFO draining into the register-file write port, with bypass lookups
module regfile_writeback_queue #(
    parameter int BIT_NUMBER  = 64,
    parameter int ADDR_NUMBER = 5,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [ADDR_NUMBER-1:0]   in_addr,
    input  logic [BIT_NUMBER-1:0]    in_data,
    output logic                     in_ready,
    input  logic                     wb_stall,
    input  logic                     flush,
    output logic                     write_enable,
    output logic [ADDR_NUMBER-1:0]   dest_addr,
    output logic [BIT_NUMBER-1:0]    write_data,
    input  logic [ADDR_NUMBER-1:0]   lk_addr_1,
    input  logic [ADDR_NUMBER-1:0]   lk_addr_2,
    output logic                     lk_hit_1,
    output logic                     lk_hit_2,
    output logic [BIT_NUMBER-1:0]    lk_data_1,
    output logic [BIT_NUMBER-1:0]    lk_data_2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [ADDR_NUMBER-1:0] addr_q [DEPTH];
    logic [BIT_NUMBER-1:0]  data_q [DEPTH];
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   push, pop, busy;

    assign busy         = count_q != '0;
    assign in_ready     = !flush && (count_q < CW'(DEPTH));
    assign write_enable = busy && !wb_stall && !flush;
    assign push         = in_valid && in_ready;
    assign pop          = write_enable;
    assign dest_addr    = busy ? addr_q[head_q] : '0;
    assign write_data   = busy ? data_q[head_q] : '0;
    assign count        = count_q;

    // Youngest match wins: scan oldest to youngest so later hits overwrite earlier ones.
    function automatic logic [BIT_NUMBER:0] lookup(input logic [ADDR_NUMBER-1:0] a);
        logic [BIT_NUMBER:0] r;
        logic [PW-1:0]       idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == a) r = {1'b1, data_q[idx]};
        end
        return r;
    endfunction

    assign {lk_hit_1, lk_data_1} = lookup(lk_addr_1);
    assign {lk_hit_2, lk_data_2} = lookup(lk_addr_2);

    // Pointer, occupancy and valid-bit next state; flush overrides push and pop.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (push) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are qualified by valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: scoreboard bench for the writeback queue
module tb_regfile_writeback_queue;
    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    logic        clk = 0, reset = 1;
    logic        in_valid = 0, wb_stall = 0, flush = 0;
    logic [4:0]  in_addr = 0, lk_addr_1 = 0, lk_addr_2 = 0;
    logic [63:0] in_data = 0;
    logic        in_ready, write_enable, lk_hit_1, lk_hit_2;
    logic [4:0]  dest_addr;
    logic [63:0] write_data, lk_data_1, lk_data_2;
    logic [2:0]  count;

    ent_t sb[$];
    int   errors = 0, checks = 0;

    regfile_writeback_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_ready(in_ready), .wb_stall(wb_stall), .flush(flush), .write_enable(write_enable),
        .dest_addr(dest_addr), .write_data(write_data), .lk_addr_1(lk_addr_1), .lk_addr_2(lk_addr_2),
        .lk_hit_1(lk_hit_1), .lk_hit_2(lk_hit_2), .lk_data_1(lk_data_1), .lk_data_2(lk_data_2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void lk_model(input logic [4:0] a, output logic h, output logic [63:0] d);
        h = 0;
        d = 0;
        foreach (sb[i]) if (sb[i].a == a) begin
            h = 1;
            d = sb[i].d;
        end
    endfunction

    // Reference model evaluated mid-cycle, then advanced to the state after the next rising edge.
    always @(negedge clk) begin
        logic        h, exp_ready, exp_we;
        logic [63:0] d;
        ent_t        e;
        if (reset) begin
            sb.delete();
            check("rst_we", write_enable, 0);
            check("rst_cnt", count, 0);
            check("rst_rdy", in_ready, 1);
            check("rst_hit", {lk_hit_1, lk_hit_2}, 0);
            check("rst_dest", dest_addr, 0);
            check("rst_wdata", write_data, 0);
        end else begin
            exp_ready = !flush && sb.size() < 4;
            exp_we    = sb.size() != 0 && !wb_stall && !flush;
            check("in_ready", in_ready, exp_ready);
            check("write_enable", write_enable, exp_we);
            check("count", count, sb.size());
            lk_model(lk_addr_1, h, d);
            check("lk_hit_1", lk_hit_1, h);
            check("lk_data_1", lk_data_1, d);
            lk_model(lk_addr_2, h, d);
            check("lk_hit_2", lk_hit_2, h);
            check("lk_data_2", lk_data_2, d);
            if (sb.size() == 0) begin
                check("dest_empty", dest_addr, 0);
                check("wdata_empty", write_data, 0);
            end else begin
                check("dest_addr", dest_addr, sb[0].a);
                check("write_data", write_data, sb[0].d);
            end
            if (flush) sb.delete();
            else begin
                if (exp_we) e = sb.pop_front();
                if (in_valid && exp_ready) sb.push_back({in_addr, in_data});
            end
        end
    end

    task automatic step(input logic v, input logic [4:0] a, input logic [63:0] d, input logic st, input logic fl);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wb_stall = st;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 0;
        flush    = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        // single push, one-cycle latency
        step(1, 3, 64'hAA, 0, 0);
        check("s1_we", write_enable, 1);
        check("s1_dest", dest_addr, 3);
        check("s1_data", write_data, 64'hAA);
        step(0, 0, 0, 0, 0);
        check("s1_cnt", count, 0);
        // fill under stall, then drain in order
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 64'(i * 16), 1, 0);
        check("s2_rdy", in_ready, 0);
        check("s2_cnt", count, 4);
        step(1, 5, 64'h55, 1, 0);
        check("s2_cnt5", count, 4);
        wb_stall = 0;
        for (int i = 1; i <= 4; i++) begin
            #0 check("s2_order", dest_addr, 5'(i));
            step(0, 0, 0, 0, 0);
        end
        check("s2_empty", count, 0);
        // youngest match on duplicate address
        step(1, 7, 64'h11, 1, 0);
        step(1, 7, 64'h22, 1, 0);
        lk_addr_1 = 7;
        lk_addr_2 = 9;
        #1;
        check("s3_hit1", lk_hit_1, 1);
        check("s3_data1", lk_data_1, 64'h22);
        check("s3_hit2", lk_hit_2, 0);
        check("s3_data2", lk_data_2, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        // full queue with continuous in_valid, wraps several times
        for (int i = 0; i < 4; i++) step(1, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1, 0);
        for (int i = 0; i < 24; i++) begin
            lk_addr_1 = 5'($urandom_range(0, 31));
            lk_addr_2 = sb.size() != 0 ? sb[sb.size() - 1].a : 5'd0;
            step(1, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 0, 0);
        end
        repeat (5) step(0, 0, 0, 0, 0);
        // flush with a concurrent in_valid
        for (int i = 10; i <= 12; i++) step(1, 5'(i), 64'(i), 1, 0);
        lk_addr_1 = 10;
        lk_addr_2 = 12;
        in_valid  = 1;
        in_addr   = 13;
        flush     = 1;
        #1;
        check("s5_rdy", in_ready, 0);
        check("s5_we", write_enable, 0);
        check("s5_prehit", lk_hit_1, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        flush    = 0;
        check("s5_cnt", count, 0);
        check("s5_hit1", lk_hit_1, 0);
        check("s5_hit2", lk_hit_2, 0);
        // asynchronous reset mid-cycle
        step(1, 20, 64'h20, 1, 0);
        step(1, 21, 64'h21, 1, 0);
        lk_addr_1 = 20;
        wb_stall  = 0;
        check("s6_pre", count, 2);
        #2 reset = 1;
        #1;
        check("s6_we", write_enable, 0);
        check("s6_cnt", count, 0);
        check("s6_hit", lk_hit_1, 0);
        #3 reset = 0;
        @(posedge clk);
        #1;
        step(1, 3, 64'hAA, 0, 0);
        check("s6_we2", write_enable, 1);
        check("s6_dest2", dest_addr, 3);
        check("s6_data2", write_data, 64'hAA);
        // random traffic
        for (int i = 0; i < 120; i++) begin
            lk_addr_1 = 5'($urandom_range(0, 7));
            lk_addr_2 = 5'($urandom_range(0, 7));
            step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        repeat (6) step(0, 0, 0, 0, 0);
        check("final_cnt", count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
